// File: rtl/vga_batalha_pkg.sv
// Shared constants and types for the battleship board-drawing blocks.
package vga_batalha_pkg;

    localparam int unsigned GRADE        = 10;
    localparam int unsigned TAM_CELULA   = 32;
    localparam int unsigned MAX_CELULAS  = 7;
    localparam int unsigned X_OFS        = 3;
    localparam int unsigned Y_OFS        = 7;
    localparam int unsigned CELULA_PASSO = 8;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned CEL_W    = 4;
    localparam int unsigned TAM_W    = 3;
    localparam int unsigned VEC_W    = 64;
    localparam int unsigned COR_W    = 8;
    localparam int unsigned QUADRO_W = 5;
    localparam int unsigned OFS_W    = $clog2(TAM_CELULA);
    localparam int unsigned LARGURA  = GRADE * TAM_CELULA;

    // Stage-1 result: which board cell the raster is on and how it sits in it.
    typedef struct packed {
        logic [CEL_W-1:0] coluna;
        logic [CEL_W-1:0] linha;
        logic             dentro;
        logic             borda;
        logic             video;
    } celula_t;

    // Extracts the 4-bit coordinate at offset ofs of packed ship cell k.
    function automatic logic [CEL_W-1:0] campo_celula(input logic [VEC_W-1:0] vec,
                                                      input int unsigned      k,
                                                      input int unsigned      ofs);
        return CEL_W'(vec >> (k * CELULA_PASSO + ofs));
    endfunction

endpackage

// File: rtl/vga_celula_grade.sv
// Registered mapping of a raster pixel onto the 10x10 board: cell, in-board and gap flags.
module vga_celula_grade
    import vga_batalha_pkg::*;
#(
    parameter int unsigned ORIGEM_X = 160,
    parameter int unsigned ORIGEM_Y = 80
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] pixel_x_i,
    input  logic [COORD_W-1:0] pixel_y_i,
    input  logic               video_on_i,
    output celula_t            celula_o
);

    localparam int unsigned DX_W = COORD_W + 1;

    logic [DX_W-1:0] dx;
    logic [DX_W-1:0] dy;
    celula_t         celula_d;
    celula_t         celula_q;

    // Pixels left of / above the origin wrap to large values and fail the range test.
    always_comb begin
        dx = {1'b0, pixel_x_i} - DX_W'(ORIGEM_X);
        dy = {1'b0, pixel_y_i} - DX_W'(ORIGEM_Y);
        celula_d        = '0;
        celula_d.coluna = CEL_W'(dx >> OFS_W);
        celula_d.linha  = CEL_W'(dy >> OFS_W);
        celula_d.dentro = (dx < DX_W'(LARGURA)) && (dy < DX_W'(LARGURA));
        celula_d.borda  = (dx[OFS_W-1:0] == '0) || (dx[OFS_W-1:0] == '1) ||
                          (dy[OFS_W-1:0] == '0) || (dy[OFS_W-1:0] == '1);
        celula_d.video  = video_on_i;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            celula_q <= '0;
        end else begin
            celula_q <= celula_d;
        end
    end

    assign celula_o = celula_q;

endmodule

// File: rtl/vga_desenho_embarcacao.sv
// Draws one ship on the board: frame-latched cell list, 2-stage pixel pipeline, selection blink.
module vga_desenho_embarcacao
    import vga_batalha_pkg::*;
#(
    parameter int unsigned      ORIGEM_X       = 160,
    parameter int unsigned      ORIGEM_Y       = 80,
    parameter logic [COR_W-1:0] COR_EMBARCACAO = 8'b101_101_10
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               novoQuadro,
    input  logic [COORD_W-1:0] pixelX,
    input  logic [COORD_W-1:0] pixelY,
    input  logic               videoOn,
    input  logic [VEC_W-1:0]   posicoesEmbarcacao,
    input  logic [TAM_W-1:0]   tamanho,
    input  logic               selecionada,
    output logic               desenhaPixel,
    output logic [COR_W-1:0]   corPixel,
    output logic               pixelValido,
    output logic               posicaoInvalida
);

    celula_t celula;

    vga_celula_grade #(
        .ORIGEM_X (ORIGEM_X),
        .ORIGEM_Y (ORIGEM_Y)
    ) u_celula_grade (
        .clock      (clock),
        .reset_n    (reset_n),
        .pixel_x_i  (pixelX),
        .pixel_y_i  (pixelY),
        .video_on_i (videoOn),
        .celula_o   (celula)
    );

    logic [VEC_W-1:0]    vec_q,       vec_d;
    logic [TAM_W-1:0]    tam_q,       tam_d;
    logic                sel_q,       sel_d;
    logic [QUADRO_W-1:0] quadro_q,    quadro_d;
    logic                nq_atraso_q;
    logic [VEC_W-1:0]    vec_ativo_q;
    logic [TAM_W-1:0]    tam_ativo_q;
    logic                apaga_q,     apaga_d;
    logic                desenha_q,   desenha_d;
    logic [COR_W-1:0]    cor_q,       cor_d;
    logic                valido_q,    valido_d;
    logic                invalida_q,  invalida_d;
    logic                acerto;
    logic                cel_invalida;

    // The *_ativo copies lag the shadows by one cycle so a pixel presented together
    // with novoQuadro still sees the previous frame's ship.
    always_comb begin
        vec_d        = vec_q;
        tam_d        = tam_q;
        sel_d        = sel_q;
        quadro_d     = quadro_q;
        invalida_d   = invalida_q;
        acerto       = 1'b0;
        cel_invalida = 1'b0;

        if (novoQuadro) begin
            vec_d    = posicoesEmbarcacao;
            tam_d    = tamanho;
            sel_d    = selecionada;
            quadro_d = quadro_q + QUADRO_W'(1);
        end

        for (int unsigned k = 0; k < MAX_CELULAS; k++) begin
            if ((TAM_W'(k) < tam_ativo_q) &&
                (campo_celula(vec_ativo_q, k, X_OFS) < CEL_W'(GRADE)) &&
                (campo_celula(vec_ativo_q, k, Y_OFS) < CEL_W'(GRADE)) &&
                (campo_celula(vec_ativo_q, k, X_OFS) == celula.coluna) &&
                (campo_celula(vec_ativo_q, k, Y_OFS) == CEL_W'(GRADE - 1) - celula.linha)) begin
                acerto = 1'b1;
            end
            if ((TAM_W'(k) < tam_q) &&
                ((campo_celula(vec_q, k, X_OFS) >= CEL_W'(GRADE)) ||
                 (campo_celula(vec_q, k, Y_OFS) >= CEL_W'(GRADE)))) begin
                cel_invalida = 1'b1;
            end
        end

        if (nq_atraso_q) begin
            invalida_d = cel_invalida;
        end

        apaga_d   = sel_q & quadro_q[QUADRO_W-1];
        desenha_d = celula.dentro & ~celula.borda & celula.video & acerto & ~apaga_q;
        cor_d     = desenha_d ? COR_EMBARCACAO : '0;
        valido_d  = celula.video;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vec_q       <= '0;
            tam_q       <= '0;
            sel_q       <= 1'b0;
            quadro_q    <= '0;
            nq_atraso_q <= 1'b0;
            vec_ativo_q <= '0;
            tam_ativo_q <= '0;
            apaga_q     <= 1'b0;
            desenha_q   <= 1'b0;
            cor_q       <= '0;
            valido_q    <= 1'b0;
            invalida_q  <= 1'b0;
        end else begin
            vec_q       <= vec_d;
            tam_q       <= tam_d;
            sel_q       <= sel_d;
            quadro_q    <= quadro_d;
            nq_atraso_q <= novoQuadro;
            vec_ativo_q <= vec_q;
            tam_ativo_q <= tam_q;
            apaga_q     <= apaga_d;
            desenha_q   <= desenha_d;
            cor_q       <= cor_d;
            valido_q    <= valido_d;
            invalida_q  <= invalida_d;
        end
    end

    assign desenhaPixel    = desenha_q;
    assign corPixel        = cor_q;
    assign pixelValido     = valido_q;
    assign posicaoInvalida = invalida_q;

endmodule

// File: tb/tb_vga_desenho_embarcacao.sv
// Bench for vga_desenho_embarcacao: directed scenarios plus random frames against a pixel-level model.
module tb_vga_desenho_embarcacao;

    localparam int         ORX = 160;
    localparam int         ORY = 80;
    localparam logic [7:0] COR = 8'b101_101_10;

    logic        clock;
    logic        reset_n;
    logic        novoQuadro;
    logic [9:0]  pixelX;
    logic [9:0]  pixelY;
    logic        videoOn;
    logic [63:0] posicoesEmbarcacao;
    logic [2:0]  tamanho;
    logic        selecionada;
    logic        desenhaPixel;
    logic [7:0]  corPixel;
    logic        pixelValido;
    logic        posicaoInvalida;

    vga_desenho_embarcacao #(
        .ORIGEM_X       (ORX),
        .ORIGEM_Y       (ORY),
        .COR_EMBARCACAO (COR)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .novoQuadro         (novoQuadro),
        .pixelX             (pixelX),
        .pixelY             (pixelY),
        .videoOn            (videoOn),
        .posicoesEmbarcacao (posicoesEmbarcacao),
        .tamanho            (tamanho),
        .selecionada        (selecionada),
        .desenhaPixel       (desenhaPixel),
        .corPixel           (corPixel),
        .pixelValido        (pixelValido),
        .posicaoInvalida    (posicaoInvalida)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: what the ship looks like for the current frame.
    logic [63:0] m_vec;
    int          m_tam;
    bit          m_sel;
    int          m_frames;
    bit          m_inv, inv_pend, nq_last;
    bit          exp_draw, exp_vo;
    int          drawn;

    function automatic int cell_x(logic [63:0] v, int k);
        return int'((v >> (8 * k + 3)) & 64'hF);
    endfunction

    function automatic int cell_y(logic [63:0] v, int k);
        return int'((v >> (8 * k + 7)) & 64'hF);
    endfunction

    function automatic logic [63:0] put_cell(logic [63:0] v, int k, int x, int y);
        logic [63:0] r;
        r = v & ~(64'hF << (8 * k + 3)) & ~(64'hF << (8 * k + 7));
        r = r | (64'(x & 15) << (8 * k + 3)) | (64'(y & 15) << (8 * k + 7));
        return r;
    endfunction

    function automatic bit model_draw(int px, int py, bit vo);
        int ox, oy, col, row;
        if (!vo) return 1'b0;
        if (px < ORX || px > ORX + 319 || py < ORY || py > ORY + 319) return 1'b0;
        ox = (px - ORX) % 32;
        oy = (py - ORY) % 32;
        if (ox == 0 || ox == 31 || oy == 0 || oy == 31) return 1'b0;
        if (m_sel && (m_frames % 32) >= 16) return 1'b0;
        col = (px - ORX) / 32;
        row = (py - ORY) / 32;
        for (int k = 0; k < m_tam; k++) begin
            if (cell_x(m_vec, k) < 10 && cell_y(m_vec, k) < 10 &&
                cell_x(m_vec, k) == col && cell_y(m_vec, k) == 9 - row)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_inv(logic [63:0] v, int t);
        for (int k = 0; k < t; k++)
            if (cell_x(v, k) >= 10 || cell_y(v, k) >= 10) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel clock: present a pixel, then check the outputs for the pixel of the previous step.
    task automatic step(input int px, input int py, input bit vo, input string tag);
        bit d_new, nq_this;
        pixelX  = 10'(px);
        pixelY  = 10'(py);
        videoOn = vo;
        d_new   = model_draw(px, py, vo);
        nq_this = novoQuadro;
        @(posedge clock);
        #1;
        chk({tag, "/desenha"}, 64'(desenhaPixel), 64'(exp_draw));
        chk({tag, "/cor"}, 64'(corPixel), exp_draw ? 64'(COR) : 64'd0);
        chk({tag, "/valido"}, 64'(pixelValido), 64'(exp_vo));
        if (nq_last) m_inv = inv_pend;
        chk({tag, "/invalida"}, 64'(posicaoInvalida), 64'(m_inv));
        drawn   += int'(desenhaPixel);
        exp_draw = d_new;
        exp_vo   = vo;
        nq_last  = nq_this;
        if (nq_this) begin
            m_vec    = posicoesEmbarcacao;
            m_tam    = int'(tamanho);
            m_sel    = selecionada;
            m_frames = (m_frames + 1) % 32;
            inv_pend = model_inv(m_vec, m_tam);
        end
    endtask

    task automatic new_frame(input logic [63:0] v, input int t, input bit s,
                             input int px, input int py, input bit vo);
        posicoesEmbarcacao = v;
        tamanho            = 3'(t);
        selecionada        = s;
        novoQuadro         = 1'b1;
        step(px, py, vo, "quadro");
        novoQuadro         = 1'b0;
    endtask

    task automatic model_reset();
        m_vec = '0; m_tam = 0; m_sel = 1'b0; m_frames = 0;
        m_inv = 1'b0; inv_pend = 1'b0; nq_last = 1'b0;
        exp_draw = 1'b0; exp_vo = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, "/rst_desenha"}, 64'(desenhaPixel), 64'd0);
        chk({tag, "/rst_cor"}, 64'(corPixel), 64'd0);
        chk({tag, "/rst_valido"}, 64'(pixelValido), 64'd0);
        chk({tag, "/rst_invalida"}, 64'(posicaoInvalida), 64'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] v;
        int          k, px, py;

        reset_n = 1'b0; novoQuadro = 1'b0; pixelX = '0; pixelY = '0; videoOn = 1'b0;
        posicoesEmbarcacao = '0; tamanho = '0; selecionada = 1'b0;
        drawn = 0;
        #2;
        do_reset("inicio");

        // Cell (5,5): drawn at (336,224), neighbour column empty.
        new_frame(64'h2A8, 1, 1'b0, 0, 0, 1'b0);
        step(336, 224, 1'b1, "c55_dentro");
        step(304, 224, 1'b1, "c55_fora");
        chk("c55_dentro_direto", 64'(desenhaPixel), 64'd1);
        chk("c55_cor_direto", 64'(corPixel), 64'(COR));
        step(0, 0, 1'b0, "ocioso");
        chk("c55_fora_direto", 64'(desenhaPixel), 64'd0);

        // Cell (4,5): interior pixel drawn, gap pixel not.
        new_frame(64'h2A0, 1, 1'b0, 0, 0, 1'b0);
        step(304, 224, 1'b1, "c45_dentro");
        step(288, 224, 1'b1, "c45_borda");
        chk("c45_dentro_direto", 64'(desenhaPixel), 64'd1);
        step(0, 0, 1'b0, "ocioso");
        chk("c45_borda_direto", 64'(desenhaPixel), 64'd0);

        // Out-of-range cell (12,5): flagged, nothing drawn on the whole board.
        new_frame(put_cell(64'h0, 0, 12, 5), 1, 1'b0, 0, 0, 1'b0);
        step(0, 0, 1'b0, "inv_espera");
        chk("inv_direto", 64'(posicaoInvalida), 64'd1);
        drawn = 0;
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
                step(ORX + c * 32 + 16, ORY + r * 32 + 16, 1'b1, "inv_varre");
        step(0, 0, 1'b0, "ocioso");
        chk("inv_nada_desenhado", 64'(drawn), 64'd0);

        // Seven cells with a duplicate; cell 6 must still be drawn.
        v = '0;
        for (int i = 0; i < 6; i++) v = put_cell(v, i, 2, 3);
        v = put_cell(v, 6, 8, 0);
        new_frame(v, 7, 1'b0, 0, 0, 1'b0);
        step(ORX + 8 * 32 + 10, ORY + 9 * 32 + 20, 1'b1, "t7_cel6");
        step(ORX + 2 * 32 + 5, ORY + 6 * 32 + 5, 1'b1, "t7_dup");
        chk("t7_cel6_direto", 64'(desenhaPixel), 64'd1);
        step(0, 0, 1'b0, "ocioso");
        chk("t7_dup_direto", 64'(desenhaPixel), 64'd1);
        new_frame(v, 0, 1'b0, 0, 0, 1'b0);
        step(ORX + 2 * 32 + 5, ORY + 6 * 32 + 5, 1'b1, "t0");
        step(0, 0, 1'b0, "ocioso");
        chk("t0_direto", 64'(desenhaPixel), 64'd0);

        // Vector changes mid-frame without novoQuadro: picture must not change.
        new_frame(64'h2A8, 1, 1'b0, 0, 0, 1'b0);
        posicoesEmbarcacao = 64'h2A0;
        step(336, 224, 1'b1, "meio_antigo");
        step(304, 224, 1'b1, "meio_novo");
        chk("meio_antigo_direto", 64'(desenhaPixel), 64'd1);
        step(0, 0, 1'b0, "ocioso");
        chk("meio_novo_direto", 64'(desenhaPixel), 64'd0);

        // Mid-frame reset: outputs drop at once, nothing drawn until the next novoQuadro.
        step(336, 224, 1'b1, "pre_reset");
        do_reset("meio");
        posicoesEmbarcacao = 64'h2A8; tamanho = 3'd1;
        step(336, 224, 1'b1, "pos_reset");
        step(336, 224, 1'b1, "pos_reset");
        chk("pos_reset_direto", 64'(desenhaPixel), 64'd0);

        // Blink: counter value f%32 after f frames; drawn while below 16.
        for (int f = 1; f <= 33; f++) begin
            new_frame(64'h2A8, 1, 1'b1, 0, 0, 1'b0);
            step(336, 224, 1'b1, "pisca");
            step(0, 0, 1'b0, "ocioso");
            chk($sformatf("pisca_q%0d", f), 64'(desenhaPixel), 64'((f % 32) < 16));
        end

        // Random frames: random ships (some off-board), pixels biased onto the ship cells.
        for (int f = 0; f < 40; f++) begin
            v = {$urandom, $urandom};
            for (int i = 0; i < 7; i++) begin
                if ($urandom_range(0, 5) == 0)
                    v = put_cell(v, i, $urandom_range(10, 15), $urandom_range(0, 15));
                else
                    v = put_cell(v, i, $urandom_range(0, 9), $urandom_range(0, 9));
            end
            new_frame(v, $urandom_range(0, 7), ($urandom_range(0, 3) == 0),
                      ORX + $urandom_range(0, 319), ORY + $urandom_range(0, 319), 1'(($urandom & 1)));
            for (int p = 0; p < 50; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    k  = $urandom_range(0, 6);
                    px = ORX + cell_x(v, k) * 32 + $urandom_range(0, 31);
                    py = ORY + (9 - cell_y(v, k)) * 32 + $urandom_range(0, 31);
                end else begin
                    px = $urandom_range(0, 799);
                    py = $urandom_range(0, 524);
                end
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                step(px % 1024, py % 1024, ($urandom_range(0, 7) != 0), "aleatorio");
            end
        end
        step(0, 0, 1'b0, "fim");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
